// File: rtl/dataflow_ctrl_monitor_if.sv
// ap_ctrl handshake bundle for NUM_CH block-level interfaces.
// The block under observation drives the bundle; the monitor only listens.
interface dataflow_ctrl_monitor_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0] ap_start;
  logic [NUM_CH-1:0] ap_ready;
  logic [NUM_CH-1:0] ap_done;
  logic [NUM_CH-1:0] ap_continue;

  modport master (output ap_start, output ap_ready, output ap_done, output ap_continue);
  modport slave  (input  ap_start, input  ap_ready, input  ap_done, input  ap_continue);
endinterface

// File: rtl/dataflow_ctrl_monitor.sv
// dataflow_ctrl_monitor: per-channel ap_ctrl transaction monitor.
// Tracks txn count, last/max latency and done-stall cycles per channel;
// statistics freeze on finish and are read through a registered port.
// Optional watchdog: define MON_TIMEOUT_EN to add per-channel timeout
// detection and the `timeout` output.
//
// state     | meaning
// ----------+-------------------------------------------------------
// IDLE      | no transaction in flight
// RUN       | started, waiting for ap_done; lat_cnt counting
// DONE_HOLD | ap_done seen with ap_continue low; lat_cnt frozen
module dataflow_ctrl_monitor #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1024,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clock,
  input  logic                reset,
  dataflow_ctrl_monitor_if.slave ctrl,
  input  logic                finish,
  input  logic                rd_en,
  input  logic [CH_W-1:0]     rd_ch,
  input  logic [1:0]          rd_field,
  output logic [CNT_W-1:0]    rd_data,
  output logic                rd_valid,
  output logic                rd_err,
  output logic [NUM_CH-1:0]   proto_err,
  output logic                frozen,
  output logic                all_idle
`ifdef MON_TIMEOUT_EN
  ,
  output logic [NUM_CH-1:0]   timeout
`endif
);

  // Reject illegal parameterisations at elaboration.
  if (NUM_CH < 1 || NUM_CH > 16 || CNT_W < 1 || TIMEOUT < 1) begin : g_bad_param
    $error("dataflow_ctrl_monitor: illegal parameter value");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE_HOLD} st_t;

  st_t              st_q    [NUM_CH];
  logic [CNT_W-1:0] lat_q   [NUM_CH];
  logic [CNT_W-1:0] txn_q   [NUM_CH];
  logic [CNT_W-1:0] last_q  [NUM_CH];
  logic [CNT_W-1:0] max_q   [NUM_CH];
  logic [CNT_W-1:0] stall_q [NUM_CH];

  logic [NUM_CH-1:0] complete;
  logic [NUM_CH-1:0] stall_inc;
  logic [NUM_CH-1:0] perr_set;

  logic [CNT_W-1:0]  rd_sel;
  logic              rd_ch_ok;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Per-channel event decode; everything is masked once frozen.
  always_comb begin
    complete  = '0;
    stall_inc = '0;
    perr_set  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      case (st_q[c])
        IDLE: perr_set[c] = ctrl.ap_done[c] | (ctrl.ap_ready[c] & ~ctrl.ap_start[c]);
        RUN: begin
          complete[c]  = ctrl.ap_done[c] & ctrl.ap_continue[c];
          stall_inc[c] = ctrl.ap_done[c] & ~ctrl.ap_continue[c];
        end
        DONE_HOLD: begin
          complete[c]  = ctrl.ap_continue[c];
          stall_inc[c] = ~ctrl.ap_continue[c];
        end
        default: ;
      endcase
    end
    if (frozen) begin
      complete  = '0;
      stall_inc = '0;
      perr_set  = '0;
    end
  end

`ifdef MON_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q   [NUM_CH];
  logic [WD_W-1:0] wd_nxt [NUM_CH];

  // Watchdog next value: consecutive busy cycles, restarting with each new start.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      wd_nxt[c] = wd_q[c];
      if (st_q[c] == IDLE || complete[c])
        wd_nxt[c] = ctrl.ap_start[c] ? WD_W'(1) : '0;
      else if (wd_q[c] != WD_W'(TIMEOUT))
        wd_nxt[c] = wd_q[c] + WD_W'(1);
    end
  end
`endif

  // Channel FSMs, statistics, sticky error and freeze flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      frozen    <= 1'b0;
      proto_err <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        st_q[c]    <= IDLE;
        lat_q[c]   <= '0;
        txn_q[c]   <= '0;
        last_q[c]  <= '0;
        max_q[c]   <= '0;
        stall_q[c] <= '0;
      end
`ifdef MON_TIMEOUT_EN
      timeout <= '0;
      for (int c = 0; c < NUM_CH; c++) wd_q[c] <= '0;
`endif
    end else begin
      if (finish) frozen <= 1'b1;
      if (!frozen) begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (perr_set[c]) proto_err[c] <= 1'b1;
          if (stall_inc[c]) stall_q[c] <= sat_inc(stall_q[c]);
          if (complete[c]) begin
            txn_q[c]  <= sat_inc(txn_q[c]);
            last_q[c] <= lat_q[c];
            if (lat_q[c] > max_q[c]) max_q[c] <= lat_q[c];
          end
          case (st_q[c])
            IDLE: begin
              if (ctrl.ap_start[c]) begin
                st_q[c]  <= RUN;
                lat_q[c] <= CNT_W'(1);
              end
            end
            RUN: begin
              if (complete[c]) begin
                if (ctrl.ap_start[c]) lat_q[c] <= CNT_W'(1);
                else                  st_q[c]  <= IDLE;
              end else if (ctrl.ap_done[c]) begin
                st_q[c] <= DONE_HOLD;
              end else begin
                lat_q[c] <= sat_inc(lat_q[c]);
              end
            end
            DONE_HOLD: begin
              if (complete[c]) begin
                if (ctrl.ap_start[c]) begin
                  st_q[c]  <= RUN;
                  lat_q[c] <= CNT_W'(1);
                end else begin
                  st_q[c] <= IDLE;
                end
              end
            end
            default: st_q[c] <= IDLE;
          endcase
`ifdef MON_TIMEOUT_EN
          wd_q[c] <= wd_nxt[c];
          if (wd_nxt[c] == WD_W'(TIMEOUT)) begin
            timeout[c]   <= 1'b1;
            proto_err[c] <= 1'b1;
          end
`endif
        end
      end
    end
  end

  // Read mux over the current (pre-update) statistics.
  always_comb begin
    rd_sel   = '0;
    rd_ch_ok = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rd_ch == CH_W'(c)) begin
        rd_ch_ok = 1'b1;
        case (rd_field)
          2'd0:    rd_sel = txn_q[c];
          2'd1:    rd_sel = last_q[c];
          2'd2:    rd_sel = max_q[c];
          default: rd_sel = stall_q[c];
        endcase
      end
    end
  end

  // Registered read port, one read per cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      rd_err   <= rd_en & ~rd_ch_ok;
      if (rd_en) rd_data <= rd_ch_ok ? rd_sel : '0;
    end
  end

  // all_idle: every channel FSM parked in IDLE.
  always_comb begin
    all_idle = 1'b1;
    for (int c = 0; c < NUM_CH; c++)
      if (st_q[c] != IDLE) all_idle = 1'b0;
  end

endmodule

// File: tb/tb_dataflow_ctrl_monitor.sv
// Scoreboard bench: reads push expected results, monitors pop and compare.
// A second instance (NUM_CH=3, CNT_W=4) covers out-of-range reads and saturation.
module tb_dataflow_ctrl_monitor;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // main instance: NUM_CH=4, CNT_W=32, TIMEOUT=16
  dataflow_ctrl_monitor_if #(.NUM_CH(4)) ifm ();
  logic        finish_m, rd_en_m, rd_valid_m, rd_err_m, frozen_m, all_idle_m;
  logic [1:0]  rd_ch_m, rd_field_m;
  logic [31:0] rd_data_m;
  logic [3:0]  proto_err_m;
`ifdef MON_TIMEOUT_EN
  logic [3:0]  timeout_m;
`endif

  dataflow_ctrl_monitor #(.NUM_CH(4), .CNT_W(32), .TIMEOUT(16)) u_main (
    .clock(clock), .reset(reset), .ctrl(ifm), .finish(finish_m),
    .rd_en(rd_en_m), .rd_ch(rd_ch_m), .rd_field(rd_field_m),
    .rd_data(rd_data_m), .rd_valid(rd_valid_m), .rd_err(rd_err_m),
    .proto_err(proto_err_m), .frozen(frozen_m), .all_idle(all_idle_m)
`ifdef MON_TIMEOUT_EN
    , .timeout(timeout_m)
`endif
  );

  // aux instance: NUM_CH=3, CNT_W=4
  dataflow_ctrl_monitor_if #(.NUM_CH(3)) ifa ();
  logic        finish_a, rd_en_a, rd_valid_a, rd_err_a, frozen_a, all_idle_a;
  logic [1:0]  rd_ch_a, rd_field_a;
  logic [3:0]  rd_data_a;
  logic [2:0]  proto_err_a;
`ifdef MON_TIMEOUT_EN
  logic [2:0]  timeout_a;
`endif

  dataflow_ctrl_monitor #(.NUM_CH(3), .CNT_W(4)) u_aux (
    .clock(clock), .reset(reset), .ctrl(ifa), .finish(finish_a),
    .rd_en(rd_en_a), .rd_ch(rd_ch_a), .rd_field(rd_field_a),
    .rd_data(rd_data_a), .rd_valid(rd_valid_a), .rd_err(rd_err_a),
    .proto_err(proto_err_a), .frozen(frozen_a), .all_idle(all_idle_a)
`ifdef MON_TIMEOUT_EN
    , .timeout(timeout_a)
`endif
  );

  // scoreboards (parallel queues per instance)
  logic [31:0] qd_m[$];
  logic        qe_m[$];
  string       qn_m[$];
  logic [31:0] qd_a[$];
  logic        qe_a[$];
  string       qn_a[$];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic rd_main(input int ch, input int field, input logic [31:0] exp_d,
                         input logic exp_e, input string name);
    rd_en_m    = 1'b1;
    rd_ch_m    = ch[1:0];
    rd_field_m = field[1:0];
    qd_m.push_back(exp_d);
    qe_m.push_back(exp_e);
    qn_m.push_back(name);
    tick();
    rd_en_m = 1'b0;
  endtask

  task automatic rd_aux(input int ch, input int field, input logic [31:0] exp_d,
                        input logic exp_e, input string name);
    rd_en_a    = 1'b1;
    rd_ch_a    = ch[1:0];
    rd_field_a = field[1:0];
    qd_a.push_back(exp_d);
    qe_a.push_back(exp_e);
    qn_a.push_back(name);
    tick();
    rd_en_a = 1'b0;
  endtask

  // start in one cycle, ap_done lat cycles later
  task automatic txn_main(input int ch, input int lat);
    ifm.ap_start[ch] = 1'b1;
    tick();
    ifm.ap_start[ch] = 1'b0;
    repeat (lat - 1) tick();
    ifm.ap_done[ch] = 1'b1;
    tick();
    ifm.ap_done[ch] = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // main read monitor
  initial begin
    logic [31:0] ed;
    logic        ee;
    string       en;
    forever begin
      @(negedge clock);
      if (rd_valid_m) begin
        n_cmp++;
        if (qd_m.size() == 0) begin
          n_bad++;
          $display("FAIL main_unexpected_rd_valid: got rd_valid=1, expected 0");
        end else begin
          ed = qd_m.pop_front();
          ee = qe_m.pop_front();
          en = qn_m.pop_front();
          if (rd_data_m !== ed || rd_err_m !== ee) begin
            n_bad++;
            $display("FAIL %s: got data=%0d err=%0b, expected data=%0d err=%0b",
                     en, rd_data_m, rd_err_m, ed, ee);
          end
        end
      end
    end
  end

  // aux read monitor
  initial begin
    logic [31:0] ed;
    logic        ee;
    string       en;
    forever begin
      @(negedge clock);
      if (rd_valid_a) begin
        n_cmp++;
        if (qd_a.size() == 0) begin
          n_bad++;
          $display("FAIL aux_unexpected_rd_valid: got rd_valid=1, expected 0");
        end else begin
          ed = qd_a.pop_front();
          ee = qe_a.pop_front();
          en = qn_a.pop_front();
          if ({28'd0, rd_data_a} !== ed || rd_err_a !== ee) begin
            n_bad++;
            $display("FAIL %s: got data=%0d err=%0b, expected data=%0d err=%0b",
                     en, rd_data_a, rd_err_a, ed, ee);
          end
        end
      end
    end
  end

  // hard time limit
  initial begin
    #500000;
    $display("FAIL global_time_limit: got no finish, expected finish before 500000");
    $fatal(1, "time limit");
  end

  initial begin
    reset = 1'b1;
    ifm.ap_start = '0; ifm.ap_ready = '0; ifm.ap_done = '0; ifm.ap_continue = '1;
    ifa.ap_start = '0; ifa.ap_ready = '0; ifa.ap_done = '0; ifa.ap_continue = '1;
    finish_m = 1'b0; rd_en_m = 1'b0; rd_ch_m = '0; rd_field_m = '0;
    finish_a = 1'b0; rd_en_a = 1'b0; rd_ch_a = '0; rd_field_a = '0;
    do_reset();

    chk("reset_all_idle", all_idle_m, 1);
    chk("reset_frozen", frozen_m, 0);
    chk("reset_proto_err", proto_err_m, 0);
    chk("reset_rd_valid", rd_valid_m, 0);
    rd_main(0, 0, 0, 0, "reset_txn_ch0");

    // ch0: single transaction, latency 7
    repeat (3) tick();
    ifm.ap_ready[0] = 1'b1;
    txn_main(0, 7);
    ifm.ap_ready[0] = 1'b0;
    chk("ch0_idle_after", all_idle_m, 1);
    rd_main(0, 0, 1, 0, "ch0_txn");
    rd_main(0, 1, 7, 0, "ch0_last");
    rd_main(0, 2, 7, 0, "ch0_max");
    rd_main(0, 3, 0, 0, "ch0_stall");

    // ch1: back-to-back latencies 5, 9, 4 with start coincident with done
    ifm.ap_start[1] = 1'b1;
    tick();
    ifm.ap_start[1] = 1'b0;
    repeat (4) tick();
    ifm.ap_done[1] = 1'b1; ifm.ap_start[1] = 1'b1;
    tick();
    ifm.ap_done[1] = 1'b0; ifm.ap_start[1] = 1'b0;
    chk("ch1_b2b_busy_1", all_idle_m, 0);
    repeat (8) tick();
    ifm.ap_done[1] = 1'b1; ifm.ap_start[1] = 1'b1;
    tick();
    ifm.ap_done[1] = 1'b0; ifm.ap_start[1] = 1'b0;
    chk("ch1_b2b_busy_2", all_idle_m, 0);
    repeat (3) tick();
    ifm.ap_done[1] = 1'b1;
    tick();
    ifm.ap_done[1] = 1'b0;
    rd_main(1, 0, 3, 0, "ch1_txn");
    rd_main(1, 1, 4, 0, "ch1_last");
    rd_main(1, 2, 9, 0, "ch1_max");
    rd_main(1, 3, 0, 0, "ch1_stall");

    // ch2: latency 6, ap_continue low for 4 cycles
    ifm.ap_start[2] = 1'b1;
    tick();
    ifm.ap_start[2] = 1'b0;
    repeat (5) tick();
    ifm.ap_done[2] = 1'b1; ifm.ap_continue[2] = 1'b0;
    tick();
    tick();
    rd_main(2, 3, 2, 0, "ch2_stall_mid");
    tick();
    ifm.ap_continue[2] = 1'b1;
    rd_main(2, 0, 0, 0, "ch2_txn_preupdate");
    ifm.ap_done[2] = 1'b0;
    rd_main(2, 0, 1, 0, "ch2_txn");
    rd_main(2, 1, 6, 0, "ch2_last");
    rd_main(2, 2, 6, 0, "ch2_max");
    rd_main(2, 3, 4, 0, "ch2_stall");

    // ch3: ap_done while IDLE -> sticky proto_err
    ifm.ap_done[3] = 1'b1;
    tick();
    ifm.ap_done[3] = 1'b0;
    chk("ch3_state_unchanged", all_idle_m, 1);
    repeat (3) tick();
    chk("proto_err_sticky", proto_err_m, 4'b1000);
    do_reset();
    chk("proto_err_cleared", proto_err_m, 0);
    rd_main(1, 0, 0, 0, "ch1_txn_cleared");

    // freeze: ch0 mid-transaction, ch1 completes in the finish cycle
    ifm.ap_start[0] = 1'b1; ifm.ap_start[1] = 1'b1;
    tick();
    ifm.ap_start[0] = 1'b0; ifm.ap_start[1] = 1'b0;
    tick();
    tick();
    ifm.ap_done[1] = 1'b1; finish_m = 1'b1;
    tick();
    ifm.ap_done[1] = 1'b0; finish_m = 1'b0;
    chk("frozen_set", frozen_m, 1);
    ifm.ap_done[0] = 1'b1;
    repeat (5) tick();
    ifm.ap_done[0] = 1'b0;
    ifm.ap_start[2] = 1'b1;
    tick();
    ifm.ap_start[2] = 1'b0;
    repeat (100) tick();
    chk("frozen_sticky", frozen_m, 1);
    chk("frozen_ch0_held_busy", all_idle_m, 0);
    rd_main(0, 0, 0, 0, "frozen_ch0_txn");
    rd_main(0, 3, 0, 0, "frozen_ch0_stall");
    rd_main(1, 0, 1, 0, "frozen_ch1_txn");
    rd_main(1, 1, 3, 0, "frozen_ch1_last");
    rd_main(2, 0, 0, 0, "frozen_ch2_txn");

    // aux: out-of-range read, ready-only protocol error, saturation
    rd_aux(3, 0, 0, 1, "aux_rd_oob");
    rd_aux(2, 0, 0, 0, "aux_rd_inrange");
    ifa.ap_ready[2] = 1'b1;
    tick();
    ifa.ap_ready[2] = 1'b0;
    chk("aux_ready_proto_err", proto_err_a, 3'b100);
    for (int i = 0; i < 20; i++) begin
      ifa.ap_start[0] = 1'b1;
      tick();
      ifa.ap_start[0] = 1'b0;
      ifa.ap_done[0] = 1'b1;
      tick();
      ifa.ap_done[0] = 1'b0;
    end
    rd_aux(0, 0, 15, 0, "aux_txn_saturated");
    rd_aux(0, 1, 1, 0, "aux_last_lat1");
    ifa.ap_start[1] = 1'b1;
    tick();
    ifa.ap_start[1] = 1'b0;
    repeat (19) tick();
    ifa.ap_done[1] = 1'b1;
    tick();
    ifa.ap_done[1] = 1'b0;
    rd_aux(1, 1, 15, 0, "aux_last_saturated");
    rd_aux(1, 2, 15, 0, "aux_max_saturated");

`ifdef MON_TIMEOUT_EN
    do_reset();
    ifm.ap_start[0] = 1'b1;
    tick();
    ifm.ap_start[0] = 1'b0;
    repeat (14) tick();
    chk("timeout_before_limit", timeout_m[0], 0);
    tick();
    chk("timeout_at_limit", timeout_m[0], 1);
    chk("timeout_proto_err", proto_err_m, 4'b0001);
`endif

    repeat (3) tick();
    chk("main_scoreboard_drained", qd_m.size(), 0);
    chk("aux_scoreboard_drained", qd_a.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
